// File: rtl/range_ctrl_pkg.sv
// Shared types and default sizes for the range counter sequencer.
package range_ctrl_pkg;

    localparam int DEF_WIDTH  = 6;
    localparam int DEF_PASS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_e;

endpackage

// File: rtl/range_counter_ctrl.sv
// Drives an up/down/load counter through lo->hi->lo triangle passes and
// freezes it (load held high) whenever no sweep is running.
module range_counter_ctrl
    import range_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    input  logic [WIDTH-1:0]  count_in,
    output logic              load,
    output logic              u_d,
    output logic [WIDTH-1:0]  data,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [PASS_W-1:0] pass_cnt
);

    state_e              state_q, state_d;
    logic                load_q, load_d;
    logic                u_d_q, u_d_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [PASS_W-1:0]   passes_q, passes_d;

    logic [WIDTH-1:0]    next_val;
    logic [PASS_W-1:0]   pass_inc;

    // Value the counter takes on this edge; abort pins it there via load.
    assign next_val = load_q ? data_q
                    : (u_d_q ? count_in + WIDTH'(1) : count_in - WIDTH'(1));
    assign pass_inc = pass_cnt_q + PASS_W'(1);

    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        u_d_d      = u_d_q;
        data_d     = data_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        pass_cnt_d = pass_cnt_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        passes_d   = passes_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (hi > lo) begin
                        lo_d       = lo;
                        hi_d       = hi;
                        passes_d   = passes;
                        pass_cnt_d = '0;
                        data_d     = lo;
                        load_d     = 1'b1;
                        state_d    = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                load_d  = 1'b0;
                u_d_d   = 1'b1;
                state_d = ST_UP;
            end
            ST_UP: begin
                if (count_in == hi_q - WIDTH'(1)) begin
                    u_d_d   = 1'b0;
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (count_in == lo_q + WIDTH'(1)) begin
                    pass_cnt_d = pass_inc;
                    if (passes_q != '0 && pass_inc == passes_q) begin
                        load_d  = 1'b1;
                        data_d  = lo_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        u_d_d   = 1'b1;
                        state_d = ST_UP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides any turn or completion decided above.
        if (abort && state_q != ST_IDLE) begin
            data_d     = next_val;
            load_d     = 1'b1;
            done_d     = 1'b0;
            pass_cnt_d = pass_cnt_q;
            state_d    = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            load_q     <= 1'b1;
            u_d_q      <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            pass_cnt_q <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            passes_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            u_d_q      <= u_d_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            pass_cnt_q <= pass_cnt_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            passes_q   <= passes_d;
        end
    end

    assign load     = load_q;
    assign u_d      = u_d_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_range_counter_ctrl.sv
// Randomized bench: controller plus a behavioural up/down/load counter,
// checked against a closed-form triangle-trajectory model.
module tb_range_counter_ctrl;

    localparam int W  = 6;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0, abort = 1'b0;
    logic [W-1:0]  lo_i = '0, hi_i = '0;
    logic [PW-1:0] passes_i = '0;
    logic [W-1:0]  count;
    logic          load, u_d, busy, done, cfg_err;
    logic [W-1:0]  data;
    logic [PW-1:0] pass_cnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // The counter being sequenced: async reset to 0, load wins over count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (load) count <= data;
        else if (u_d)  count <= count + W'(1);
        else           count <= count - W'(1);
    end

    range_counter_ctrl #(.WIDTH(W), .PASS_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lo(lo_i), .hi(hi_i), .passes(passes_i), .count_in(count),
        .load(load), .u_d(u_d), .data(data), .busy(busy), .done(done),
        .cfg_err(cfg_err), .pass_cnt(pass_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = edges after the one that sampled start.
    function automatic int traj(int lo, int hi, int ps, int k);
        int t, per, ph;
        t   = k - 1;
        per = 2 * (hi - lo);
        if (ps != 0 && t >= ps * per) return lo;
        ph = t % per;
        return lo + ((ph <= hi - lo) ? ph : per - ph);
    endfunction

    function automatic int exp_pc(int lo, int hi, int ps, int k);
        int t, per;
        t   = k - 1;
        per = 2 * (hi - lo);
        if (ps == 0) return (t / per) % (1 << PW);
        return (t / per < ps) ? t / per : ps;
    endfunction

    task automatic run_sweep(input int lo, input int hi, input int ps, input int abort_at);
        int per, dk, kend, frz;
        per  = 2 * (hi - lo);
        dk   = 1 + ps * per;
        kend = (abort_at != 0) ? abort_at + 4 : dk + 3;
        frz  = traj(lo, hi, ps, abort_at);
        lo_i = W'(lo); hi_i = W'(hi); passes_i = PW'(ps); start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_load", load, 1);
        for (int k = 1; k <= kend; k++) begin
            if (k == abort_at) abort = 1'b1;
            // Stir inputs while busy: they must all be ignored.
            if ((abort_at == 0 || k < abort_at) && (ps == 0 || k <= ps * per)) begin
                start    = ($urandom % 3 == 0);
                lo_i     = W'($urandom);
                hi_i     = W'($urandom);
                passes_i = PW'($urandom);
            end
            step();
            start = 1'b0;
            abort = 1'b0;
            chk("cfg_err_quiet", cfg_err, 0);
            if (abort_at != 0 && k >= abort_at) begin
                chk("abort_count", count, frz);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_load", load, 1);
            end else begin
                chk("count", count, traj(lo, hi, ps, k));
                chk("busy", busy, (ps == 0 || k < dk) ? 1 : 0);
                chk("done", done, (ps != 0 && k == dk) ? 1 : 0);
                chk("pass_cnt", pass_cnt, exp_pc(lo, hi, ps, k));
            end
        end
    endtask

    initial begin
        int c0, lo, span, ps, ab;
        rst = 1'b1;
        #3;
        chk("rst_load", load, 1);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_u_d", u_d, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        #7 rst = 1'b0;
        repeat (10) begin
            step();
            chk("idle_count", count, 0);
            chk("idle_busy", busy, 0);
            chk("idle_load", load, 1);
        end

        run_sweep(20, 24, 2, 0);
        run_sweep(5, 6, 3, 0);
        run_sweep(10, 40, 0, 9);

        // Rejected configuration
        c0 = count;
        lo_i = 6'd30; hi_i = 6'd30; passes_i = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        step();
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_err_count", count, c0);

        // start together with abort in IDLE does nothing
        lo_i = 6'd3; hi_i = 6'd9; passes_i = 4'd1; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_cfg_err", cfg_err, 0);
        step();
        chk("sa_count", count, c0);

        for (int i = 0; i < 14; i++) begin
            lo   = $urandom_range(0, 50);
            span = $urandom_range(1, (63 - lo < 10) ? 63 - lo : 10);
            ps   = $urandom_range(0, 3);
            if (ps == 0) ab = $urandom_range(1, 40);
            else ab = ($urandom % 3 == 0) ? $urandom_range(1, ps * 2 * span) : 0;
            run_sweep(lo, lo + span, ps, ab);
        end
        run_sweep(61, 63, 1, 0);
        run_sweep(0, 1, 2, 0);

        // Reset while falling
        lo_i = 6'd20; hi_i = 6'd24; passes_i = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("pre_rst_count", count, 23);
        chk("pre_rst_u_d", u_d, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_load", load, 1);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_u_d", u_d, 0);
        chk("mid_rst_pass_cnt", pass_cnt, 0);
        chk("mid_rst_count", count, 0);
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("post_rst_count", count, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
